// File: rtl/pipelined_mac_if.sv
// Operand/result bundle for pipelined_mac: the producer drives operands and enable,
// the MAC drives back the per-vector result.
interface pipelined_mac_if #(
  parameter int unsigned A_W   = 4,
  parameter int unsigned B_W   = 4,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 8
) ();
  logic             ena;
  logic             in_valid;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             last;
  logic             out_valid;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] cnt_out;
  logic             ovf;

  modport master (
    output ena, in_valid, a, b, last,
    input  out_valid, acc_out, cnt_out, ovf
  );

  modport slave (
    input  ena, in_valid, a, b, last,
    output out_valid, acc_out, cnt_out, ovf
  );
endinterface

// File: rtl/pipelined_mac.sv
// Three-stage unsigned multiply-accumulate over last-delimited vectors, with stall
// (ena), element count, and wrap-or-saturate overflow handling.
module pipelined_mac #(
  parameter int unsigned A_W      = 4,
  parameter int unsigned B_W      = 4,
  parameter int unsigned ACC_W    = 12,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input logic           clk,
  input logic           rst,
  pipelined_mac_if.slave bus
);
  localparam int unsigned P_W = A_W + B_W;

  // S1: registered operands
  logic             s1_valid_q, s1_last_q;
  logic [A_W-1:0]   s1_a_q;
  logic [B_W-1:0]   s1_b_q;
  // S2: registered product
  logic             s2_valid_q, s2_last_q;
  logic [ACC_W-1:0] s2_prod_q;
  // S3: running vector state and result registers
  logic [ACC_W-1:0] run_acc_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic             run_ovf_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] acc_out_q;
  logic [CNT_W-1:0] cnt_out_q;
  logic             ovf_q;

  logic [P_W-1:0]   prod;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;

  always_comb begin
    prod  = {{B_W{1'b0}}, s1_a_q} * {{A_W{1'b0}}, s1_b_q};
    sum   = {1'b0, run_acc_q} + {1'b0, s2_prod_q};
    ovf_d = run_ovf_q | sum[ACC_W];
    // A clamped accumulator stays at max because any further sum also carries out.
    if (SATURATE && sum[ACC_W]) acc_d = '1;
    else                        acc_d = sum[ACC_W-1:0];
    cnt_d = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      run_acc_q   <= '0;
      run_cnt_q   <= '0;
      run_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      cnt_out_q   <= '0;
      ovf_q       <= 1'b0;
    end else if (bus.ena) begin
      s1_valid_q  <= bus.in_valid;
      s1_last_q   <= bus.in_valid & bus.last;
      s1_a_q      <= bus.a;
      s1_b_q      <= bus.b;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_prod_q   <= ACC_W'(prod);
      out_valid_q <= 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          acc_out_q   <= acc_d;
          cnt_out_q   <= cnt_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
          run_acc_q   <= '0;
          run_cnt_q   <= '0;
          run_ovf_q   <= 1'b0;
        end else begin
          run_acc_q <= acc_d;
          run_cnt_q <= cnt_d;
          run_ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.cnt_out   = cnt_out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_mac.sv
// Directed bench: four MAC configurations share one stimulus stream; each step checks
// the configuration whose behaviour it targets.
module tb_pipelined_mac;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       last = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_mac_if #(.A_W(4), .B_W(4), .ACC_W(12), .CNT_W(8)) if_def ();
  pipelined_mac_if #(.A_W(4), .B_W(4), .ACC_W(8),  .CNT_W(8)) if_sat ();
  pipelined_mac_if #(.A_W(4), .B_W(4), .ACC_W(8),  .CNT_W(8)) if_wrap ();
  pipelined_mac_if #(.A_W(4), .B_W(4), .ACC_W(12), .CNT_W(2)) if_cnt ();

  assign if_def.ena  = ena;  assign if_def.in_valid  = in_valid;  assign if_def.last  = last;
  assign if_def.a    = a;    assign if_def.b         = b;
  assign if_sat.ena  = ena;  assign if_sat.in_valid  = in_valid;  assign if_sat.last  = last;
  assign if_sat.a    = a;    assign if_sat.b         = b;
  assign if_wrap.ena = ena;  assign if_wrap.in_valid = in_valid;  assign if_wrap.last = last;
  assign if_wrap.a   = a;    assign if_wrap.b        = b;
  assign if_cnt.ena  = ena;  assign if_cnt.in_valid  = in_valid;  assign if_cnt.last  = last;
  assign if_cnt.a    = a;    assign if_cnt.b         = b;

  pipelined_mac #(.A_W(4), .B_W(4), .ACC_W(12), .CNT_W(8), .SATURATE(1'b0)) u_def (
    .clk(clk), .rst(rst), .bus(if_def)
  );
  pipelined_mac #(.A_W(4), .B_W(4), .ACC_W(8), .CNT_W(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(if_sat)
  );
  pipelined_mac #(.A_W(4), .B_W(4), .ACC_W(8), .CNT_W(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .bus(if_wrap)
  );
  pipelined_mac #(.A_W(4), .B_W(4), .ACC_W(12), .CNT_W(2), .SATURATE(1'b0)) u_cnt (
    .clk(clk), .rst(rst), .bus(if_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Present one input cycle, then settle just past the edge that sampled it.
  task automatic cyc(input logic en, input logic v, input logic [3:0] aa, input logic [3:0] bb,
                     input logic ll);
    ena = en; in_valid = v; a = aa; b = bb; last = ll;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    idle(); idle();
    rst = 1'b0;
    chk("rst_out_valid", 32'(if_def.out_valid), 32'd0);
    chk("rst_acc_out",   32'(if_def.acc_out),   32'd0);
    chk("rst_cnt_out",   32'(if_def.cnt_out),   32'd0);
    chk("rst_ovf",       32'(if_def.ovf),       32'd0);

    // Four-element vector, continuous: 15+225+14+0 = 254
    cyc(1, 1, 4'd3, 4'd5, 0);
    cyc(1, 1, 4'd15, 4'd15, 0);
    cyc(1, 1, 4'd7, 4'd2, 0);
    cyc(1, 1, 4'd0, 4'd9, 1);
    idle();
    chk("t1_no_early_valid", 32'(if_def.out_valid), 32'd0);
    idle();
    chk("t1_out_valid", 32'(if_def.out_valid), 32'd1);
    chk("t1_acc_out",   32'(if_def.acc_out),   32'd254);
    chk("t1_cnt_out",   32'(if_def.cnt_out),   32'd4);
    chk("t1_ovf",       32'(if_def.ovf),       32'd0);
    idle();
    chk("t1_pulse_end", 32'(if_def.out_valid), 32'd0);
    chk("t1_acc_hold",  32'(if_def.acc_out),   32'd254);

    // Same vector with bubbles and a two-cycle stall carrying junk inputs
    cyc(1, 1, 4'd3, 4'd5, 0);
    idle();
    cyc(1, 1, 4'd15, 4'd15, 0);
    idle();
    cyc(0, 1, 4'd15, 4'd15, 1);
    cyc(0, 1, 4'd15, 4'd15, 1);
    cyc(1, 1, 4'd7, 4'd2, 0);
    cyc(1, 1, 4'd0, 4'd9, 1);
    idle();
    chk("t2_no_early_valid", 32'(if_def.out_valid), 32'd0);
    cyc(0, 1, 4'd15, 4'd15, 1);
    chk("t2_stall_no_valid", 32'(if_def.out_valid), 32'd0);
    idle();
    chk("t2_out_valid", 32'(if_def.out_valid), 32'd1);
    chk("t2_acc_out",   32'(if_def.acc_out),   32'd254);
    chk("t2_cnt_out",   32'(if_def.cnt_out),   32'd4);
    chk("t2_ovf",       32'(if_def.ovf),       32'd0);
    cyc(0, 0, 4'd0, 4'd0, 0);
    chk("t2_valid_frozen", 32'(if_def.out_valid), 32'd1);
    idle();
    chk("t2_pulse_end", 32'(if_def.out_valid), 32'd0);

    // Overflow on an 8-bit accumulator: 225+225 = 450
    cyc(1, 1, 4'd15, 4'd15, 0);
    cyc(1, 1, 4'd15, 4'd15, 1);
    idle(); idle();
    chk("t3_sat_valid", 32'(if_sat.out_valid), 32'd1);
    chk("t3_sat_acc",   32'(if_sat.acc_out),   32'd255);
    chk("t3_sat_cnt",   32'(if_sat.cnt_out),   32'd2);
    chk("t3_sat_ovf",   32'(if_sat.ovf),       32'd1);
    chk("t3_wrap_acc",  32'(if_wrap.acc_out),  32'd194);
    chk("t3_wrap_cnt",  32'(if_wrap.cnt_out),  32'd2);
    chk("t3_wrap_ovf",  32'(if_wrap.ovf),      32'd1);
    chk("t3_def_acc",   32'(if_def.acc_out),   32'd450);
    chk("t3_def_ovf",   32'(if_def.ovf),       32'd0);
    idle();
    cyc(1, 1, 4'd1, 4'd1, 1);
    idle(); idle();
    chk("t3_sat_next_acc",  32'(if_sat.acc_out),  32'd1);
    chk("t3_sat_next_ovf",  32'(if_sat.ovf),      32'd0);
    chk("t3_wrap_next_acc", 32'(if_wrap.acc_out), 32'd1);
    chk("t3_wrap_next_ovf", 32'(if_wrap.ovf),     32'd0);
    idle();

    // Back-to-back single-element vectors
    cyc(1, 1, 4'd15, 4'd15, 1);
    cyc(1, 1, 4'd2, 4'd3, 1);
    idle();
    chk("t4_first_valid", 32'(if_def.out_valid), 32'd1);
    chk("t4_first_acc",   32'(if_def.acc_out),   32'd225);
    chk("t4_first_cnt",   32'(if_def.cnt_out),   32'd1);
    idle();
    chk("t4_second_valid", 32'(if_def.out_valid), 32'd1);
    chk("t4_second_acc",   32'(if_def.acc_out),   32'd6);
    chk("t4_second_cnt",   32'(if_def.cnt_out),   32'd1);
    idle();
    chk("t4_pulse_end", 32'(if_def.out_valid), 32'd0);

    // Reset discards a partial vector and drops the element presented with it
    cyc(1, 1, 4'd4, 4'd4, 0);
    cyc(1, 1, 4'd4, 4'd4, 0);
    cyc(1, 1, 4'd4, 4'd4, 0);
    chk("t5_pre_rst_valid", 32'(if_def.out_valid), 32'd0);
    rst = 1'b1;
    cyc(1, 1, 4'd7, 4'd7, 1);
    rst = 1'b0;
    chk("t5_rst_acc", 32'(if_def.acc_out), 32'd0);
    chk("t5_rst_cnt", 32'(if_def.cnt_out), 32'd0);
    idle(); idle();
    chk("t5_no_phantom_valid", 32'(if_def.out_valid), 32'd0);
    cyc(1, 1, 4'd1, 4'd2, 1);
    idle(); idle();
    chk("t5_out_valid", 32'(if_def.out_valid), 32'd1);
    chk("t5_acc_out",   32'(if_def.acc_out),   32'd2);
    chk("t5_cnt_out",   32'(if_def.cnt_out),   32'd1);
    idle();

    // Count saturation with CNT_W=2
    for (int i = 0; i < 5; i++) cyc(1, 1, 4'd1, 4'd1, (i == 4));
    idle(); idle();
    chk("t6_out_valid", 32'(if_cnt.out_valid), 32'd1);
    chk("t6_acc_out",   32'(if_cnt.acc_out),   32'd5);
    chk("t6_cnt_out",   32'(if_cnt.cnt_out),   32'd3);
    chk("t6_ovf",       32'(if_cnt.ovf),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
